// File: rtl/m8088_bus_bridge.sv
// m8088_bus_bridge: turns each m8088 minimum-mode bus cycle into one req/ack fabric
// transaction, holding READY low until the fabric answers or the cycle times out.
module m8088_bus_bridge #(
    parameter int ADDR_W   = 20,
    parameter int MIN_WAIT = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic              CORE_CLK,
    input  logic              RESET_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    input  logic              ALE,
    input  logic              RD_n,
    input  logic              WR_n,
    input  logic              INTA_n,
    input  logic              IOM,
    output logic              READY,
    input  logic [7:0]        int_vector,
    output logic              sys_req,
    output logic              sys_we,
    output logic              sys_io,
    output logic [ADDR_W-1:0] sys_addr,
    output logic [7:0]        sys_wdata,
    input  logic              sys_ack,
    input  logic [7:0]        sys_rdata,
    output logic              bus_error
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ARMED   = 3'd1;
    localparam logic [2:0] WSETTLE = 3'd2;
    localparam logic [2:0] REQ     = 3'd3;
    localparam logic [2:0] WAITS   = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0] state;
    logic       ale_d;
    logic [7:0] timer;
    logic [3:0] wcnt;
    logic       ale_fall;
    logic       busy;

    assign ale_fall = ale_d & ~ALE;
    assign busy     = state != IDLE && state != DONE;

    always_ff @(posedge CORE_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state     <= IDLE;
            ale_d     <= 1'b0;
            timer     <= 8'd0;
            wcnt      <= 4'd0;
            cpu_din   <= 8'hFF;
            READY     <= 1'b1;
            sys_req   <= 1'b0;
            sys_we    <= 1'b0;
            sys_io    <= 1'b0;
            sys_addr  <= '0;
            sys_wdata <= 8'd0;
            bus_error <= 1'b0;
        end else begin
            ale_d     <= ALE;
            bus_error <= 1'b0;
            // a new ALE while a cycle is in flight means the core gave up on it
            if (ale_fall && busy) begin
                sys_req   <= 1'b0;
                bus_error <= 1'b1;
                sys_addr  <= cpu_addr;
                sys_io    <= ~IOM;
                READY     <= 1'b0;
                state     <= ARMED;
            end else begin
                case (state)
                    IDLE: begin
                        READY <= 1'b1;
                        if (ale_fall) begin
                            sys_addr <= cpu_addr;
                            sys_io   <= ~IOM;
                            READY    <= 1'b0;
                            state    <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (!INTA_n) begin
                            cpu_din <= int_vector;
                            wcnt    <= 4'(MIN_WAIT);
                            state   <= WAITS;
                        end else if (!RD_n) begin
                            sys_we  <= 1'b0;
                            sys_req <= 1'b1;
                            timer   <= 8'd0;
                            state   <= REQ;
                        end else if (!WR_n) begin
                            state <= WSETTLE;
                        end
                    end
                    WSETTLE: begin
                        sys_wdata <= cpu_dout;
                        sys_we    <= 1'b1;
                        sys_req   <= 1'b1;
                        timer     <= 8'd0;
                        state     <= REQ;
                    end
                    REQ: begin
                        timer <= timer + 8'd1;
                        // an ack on the final timer cycle still wins over the timeout
                        if (sys_ack) begin
                            sys_req <= 1'b0;
                            cpu_din <= sys_we ? cpu_din : sys_rdata;
                            wcnt    <= 4'(MIN_WAIT);
                            state   <= WAITS;
                        end else if (timer == 8'(TIMEOUT - 1)) begin
                            sys_req   <= 1'b0;
                            cpu_din   <= 8'hFF;
                            bus_error <= 1'b1;
                            wcnt      <= 4'(MIN_WAIT);
                            state     <= WAITS;
                        end
                    end
                    WAITS: begin
                        wcnt <= wcnt - 4'd1;
                        if (wcnt == 4'd0) begin
                            READY <= 1'b1;
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        if (RD_n & WR_n & INTA_n)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_m8088_bus_bridge.sv
// tb_m8088_bus_bridge: two bridges (MIN_WAIT 0 and 3, TIMEOUT 8) driven by one core/fabric
// model; each bus cycle's expected timing and data are derived from the transaction rules.
module tb_m8088_bus_bridge;
    localparam int AW = 20;
    localparam int TO = 8;

    logic          CORE_CLK = 1'b0;
    logic          RESET_n;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_dout;
    logic          ALE;
    logic          RD_n;
    logic          WR_n;
    logic          INTA_n;
    logic          IOM;
    logic [7:0]    int_vector;
    logic          sys_ack;
    logic [7:0]    sys_rdata;

    logic [7:0]    cpu_din [2];
    logic          ready [2];
    logic          sys_req [2];
    logic          sys_we [2];
    logic          sys_io [2];
    logic [AW-1:0] sys_addr [2];
    logic [7:0]    sys_wdata [2];
    logic          bus_error [2];

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_din [2];

    always #5 CORE_CLK = ~CORE_CLK;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        m8088_bus_bridge #(.ADDR_W(AW), .MIN_WAIT(g * 3), .TIMEOUT(TO)) u_dut (
            .CORE_CLK   (CORE_CLK),
            .RESET_n    (RESET_n),
            .cpu_addr   (cpu_addr),
            .cpu_dout   (cpu_dout),
            .cpu_din    (cpu_din[g]),
            .ALE        (ALE),
            .RD_n       (RD_n),
            .WR_n       (WR_n),
            .INTA_n     (INTA_n),
            .IOM        (IOM),
            .READY      (ready[g]),
            .int_vector (int_vector),
            .sys_req    (sys_req[g]),
            .sys_we     (sys_we[g]),
            .sys_io     (sys_io[g]),
            .sys_addr   (sys_addr[g]),
            .sys_wdata  (sys_wdata[g]),
            .sys_ack    (sys_ack),
            .sys_rdata  (sys_rdata),
            .bus_error  (bus_error[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CORE_CLK);
        @(negedge CORE_CLK);
    endtask

    task automatic start_cycle(input logic [AW-1:0] a, input logic iom, input logic exp_err);
        ALE = 1'b1;
        cpu_addr = a;
        IOM = iom;
        tick();
        ALE = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("ale_ready%0d", i), ready[i], 0);
            check($sformatf("ale_addr%0d", i), sys_addr[i], a);
            check($sformatf("ale_io%0d", i), sys_io[i], !iom);
            check($sformatf("ale_req%0d", i), sys_req[i], 0);
            check($sformatf("ale_err%0d", i), bus_error[i], exp_err);
        end
    endtask

    // kind: 0 read, 1 write, 2 INTA; ack_at = REQ cycle the fabric acks in (0 = never)
    task automatic run_cycle(input int kind, input logic [AW-1:0] a, input logic iom,
                             input logic [7:0] dout, input logic [7:0] vec,
                             input logic [7:0] rdata, input int ack_at);
        int req_rise = 0;
        int req_len  = 0;
        int errs [2];
        int rdy_at [2];
        bit acked;
        int exp_len;
        int exp_rise;
        errs[0] = 0; errs[1] = 0; rdy_at[0] = 0; rdy_at[1] = 0;
        cpu_dout = dout;
        int_vector = vec;
        sys_rdata = rdata;
        RD_n = kind != 0;
        WR_n = kind != 1;
        INTA_n = kind != 2;
        for (int n = 1; n <= 60 && (rdy_at[0] == 0 || rdy_at[1] == 0); n++) begin
            tick();
            sys_ack = 1'b0;
            check("req_match", sys_req[1], sys_req[0]);
            if (sys_req[0]) begin
                if (req_rise == 0) req_rise = n;
                req_len++;
                check("req_addr", sys_addr[0], a);
                check("req_io", sys_io[0], !iom);
                check("req_we", sys_we[0], kind == 1);
                if (kind == 1) check("req_wdata", sys_wdata[0], dout);
                sys_ack = req_len == ack_at;
            end
            for (int i = 0; i < 2; i++) begin
                if (bus_error[i]) errs[i]++;
                if (ready[i] && rdy_at[i] == 0) rdy_at[i] = n;
            end
        end
        sys_ack = 1'b0;
        repeat (2) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (bus_error[i]) errs[i]++;
                check($sformatf("done_ready%0d", i), ready[i], 1);
            end
        end
        acked = ack_at >= 1 && ack_at <= TO;
        exp_rise = kind == 0 ? 1 : kind == 1 ? 2 : 0;
        exp_len = kind == 2 ? 0 : acked ? ack_at : TO;
        check("req_rise", req_rise, exp_rise);
        check("req_len", req_len, exp_len);
        for (int i = 0; i < 2; i++) begin
            if (kind == 2) exp_din[i] = vec;
            else if (!acked) exp_din[i] = 8'hFF;
            else if (kind == 0) exp_din[i] = rdata;
            check($sformatf("ready_at%0d", i), rdy_at[i],
                  kind == 2 ? 2 + i * 3 : exp_rise + exp_len + i * 3 + 1);
            check($sformatf("bus_err_cnt%0d", i), errs[i], (kind != 2 && !acked) ? 1 : 0);
            check($sformatf("cpu_din%0d", i), cpu_din[i], exp_din[i]);
        end
        RD_n = 1'b1;
        WR_n = 1'b1;
        INTA_n = 1'b1;
        tick();
    endtask

    task automatic bus_cycle(input int kind, input logic [AW-1:0] a, input logic iom,
                             input logic [7:0] dout, input logic [7:0] vec,
                             input logic [7:0] rdata, input int ack_at);
        start_cycle(a, iom, 1'b0);
        run_cycle(kind, a, iom, dout, vec, rdata, ack_at);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESET_n = 1'b0;
        ALE = 1'b0;
        RD_n = 1'b1;
        WR_n = 1'b1;
        INTA_n = 1'b1;
        IOM = 1'b1;
        cpu_addr = '0;
        cpu_dout = 8'd0;
        int_vector = 8'd0;
        sys_ack = 1'b0;
        sys_rdata = 8'd0;
        exp_din[0] = 8'hFF;
        exp_din[1] = 8'hFF;
        repeat (2) @(negedge CORE_CLK);
        for (int i = 0; i < 2; i++) begin
            check("rst_din", cpu_din[i], 8'hFF);
            check("rst_ready", ready[i], 1);
            check("rst_req", sys_req[i], 0);
            check("rst_we", sys_we[i], 0);
            check("rst_io", sys_io[i], 0);
            check("rst_addr", sys_addr[i], 0);
            check("rst_wdata", sys_wdata[i], 0);
            check("rst_err", bus_error[i], 0);
        end
        RESET_n = 1'b1;
        tick();

        bus_cycle(0, 20'hF0010, 1'b1, 8'h00, 8'h00, 8'h5A, 4);
        bus_cycle(1, 20'h00040, 1'b0, 8'hC3, 8'h00, 8'h00, 2);
        bus_cycle(2, 20'h00000, 1'b0, 8'h00, 8'h21, 8'h00, 0);
        bus_cycle(0, 20'h12000, 1'b1, 8'h00, 8'h00, 8'h99, 0);
        bus_cycle(0, 20'h0ABCD, 1'b1, 8'h00, 8'h00, 8'h3C, 1);
        bus_cycle(0, 20'h0ABCE, 1'b0, 8'h00, 8'h00, 8'h6D, TO);
        bus_cycle(1, 20'h0ABCF, 1'b1, 8'h44, 8'h00, 8'h00, TO + 1);
        bus_cycle(0, 20'h00777, 1'b1, 8'h00, 8'h00, 8'h11, 3);

        start_cycle(20'h12345, 1'b1, 1'b0);
        RD_n = 1'b0;
        tick();
        tick();
        check("abort_req_before", sys_req[0], 1);
        RD_n = 1'b1;
        start_cycle(20'h54321, 1'b1, 1'b1);
        sys_rdata = 8'hEE;
        sys_ack = 1'b1;
        tick();
        sys_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("abort_ack_din%0d", i), cpu_din[i], exp_din[i]);
            check($sformatf("abort_ack_ready%0d", i), ready[i], 0);
            check($sformatf("abort_ack_err%0d", i), bus_error[i], 0);
            check($sformatf("abort_ack_req%0d", i), sys_req[i], 0);
        end
        run_cycle(0, 20'h54321, 1'b1, 8'h00, 8'h00, 8'h77, 1);

        start_cycle(20'hABCDE, 1'b1, 1'b0);
        RD_n = 1'b0;
        tick();
        check("rst_mid_req_before", sys_req[1], 1);
        #2 RESET_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_mid_req%0d", i), sys_req[i], 0);
            check($sformatf("rst_mid_ready%0d", i), ready[i], 1);
            check($sformatf("rst_mid_din%0d", i), cpu_din[i], 8'hFF);
            exp_din[i] = 8'hFF;
        end
        RD_n = 1'b1;
        @(negedge CORE_CLK);
        RESET_n = 1'b1;
        tick();

        for (int t = 0; t < 40; t++)
            bus_cycle($urandom_range(0, 2), AW'($urandom), 1'($urandom),
                      8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 10));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/m8088_bus_bridge.md
Name: m8088_bus_bridge

Overview:
Sits directly downstream of the m8088 core. It consumes the core's minimum-mode bus (ALE, RD_n, WR_n, INTA_n, IOM, addr, dout) and converts each bus cycle into a single request/acknowledge transaction on the system memory/IO fabric. It drives READY low to stretch T3 until the fabric responds, and returns read data or the interrupt vector on cpu_din.

Parameters:
ADDR_W, 20, width of latched CPU address and sys_addr
MIN_WAIT, 0, extra CORE_CLK cycles READY stays low after the data phase completes (0-15)
TIMEOUT, 255, maximum CORE_CLK cycles sys_req may stay unacknowledged before the cycle is aborted (1-255)

Ports:
CORE_CLK  in  1  single clock, rising edge; all inputs are synchronous to it
RESET_n  in  1  asynchronous active-low reset
cpu_addr  in  ADDR_W  address from the core (addr register, valid when ALE falls)
cpu_dout  in  8  write data from the core
cpu_din  out  8  read data / INTA vector to the core
ALE  in  1  address latch enable from the core
RD_n  in  1  read strobe, active low
WR_n  in  1  write strobe, active low
INTA_n  in  1  interrupt acknowledge strobe, active low
IOM  in  1  1 = memory, 0 = IO
READY  out  1  to the core READY input
int_vector  in  8  vector byte returned on INTA cycles
sys_req  out  1  fabric request, level
sys_we  out  1  1 = write
sys_io  out  1  1 = IO space
sys_addr  out  ADDR_W  fabric address
sys_wdata  out  8  fabric write data
sys_ack  in  1  one-cycle acknowledge
sys_rdata  in  8  read data, valid with sys_ack
bus_error  out  1  one-cycle pulse on timeout or abort

Behaviour:
- Reset values: cpu_din=8'hFF, READY=1, sys_req=0, sys_we=0, sys_io=0, sys_addr=0, sys_wdata=0, bus_error=0, state=IDLE.
- A reset asserted mid-transaction drops sys_req immediately (asynchronously). No partial cycle is replayed.
- Edge detect: ale_d is a registered copy of ALE. The falling edge is (ale_d & ~ALE).
- IDLE:
  - READY=1.
  - On an ALE falling edge: latch sys_addr<=cpu_addr, sys_io<=~IOM, drive READY<=0, go to ARMED.
- ARMED:
  - Strobe priority when several are low: INTA_n, then RD_n, then WR_n.
  - INTA_n=0: cpu_din<=int_vector; go to WAITS. No fabric access is made.
  - RD_n=0: sys_we<=0, sys_req<=1; go to REQ.
  - WR_n=0: go to WSETTLE. This costs one cycle because the core registers dout.
- WSETTLE: sys_wdata<=cpu_dout, sys_we<=1, sys_req<=1; go to REQ.
- REQ:
  - sys_req, sys_we, sys_addr and sys_wdata are held stable until sys_ack.
  - An 8-bit timer counts cycles with sys_req high.
  - On sys_ack: sys_req<=0. On a read, cpu_din<=sys_rdata. Go to WAITS.
  - sys_ack arriving in the same cycle the timer reaches TIMEOUT counts as success.
  - Timer reaches TIMEOUT without ack: sys_req<=0, cpu_din<=8'hFF, bus_error=1 for one cycle; go to WAITS.
- WAITS: a 4-bit counter loads MIN_WAIT and counts down. At 0 set READY<=1 and go to DONE. With MIN_WAIT=0 this state lasts exactly one cycle.
- DONE:
  - READY=1 and cpu_din is held.
  - When RD_n & WR_n & INTA_n are all 1, go to IDLE.
- sys_ack received outside REQ is ignored.
- Abort: an ALE falling edge in any state other than IDLE or DONE means the core started a new cycle.
  - sys_req<=0 and bus_error pulses.
  - The new address is latched and the state goes to ARMED, with READY held 0.
- Latency, read with an immediate ack and MIN_WAIT=0: READY rises 3 cycles after RD_n is first sampled low (ARMED, REQ, WAITS).

Test Plan:
- Memory read: ALE falls with cpu_addr=20'hF0010, IOM=1, then RD_n=0; fabric acks after 4 cycles with sys_rdata=8'h5A -> sys_addr=F0010, sys_io=0, sys_we=0, sys_req high until ack; cpu_din=5A; READY low from the ALE fall and high 1 cycle after ack.
- IO write: cpu_addr=20'h00040, IOM=0, WR_n=0, cpu_dout=8'hC3 -> sys_req rises 2 cycles after WR_n low, with sys_io=1, sys_we=1, sys_wdata=C3; after ack, DONE holds until WR_n=1, then IDLE.
- INTA cycle with int_vector=8'h21 -> no sys_req ever; cpu_din=21; READY returns to 1 within 2 cycles.
- Timeout with TIMEOUT=8: no ack -> sys_req drops after 8 cycles; bus_error pulses exactly once; cpu_din=FF; READY=1.
- MIN_WAIT=3 read: ack in the first REQ cycle -> READY rises exactly 4 cycles after ack. Then RESET_n pulled low while in REQ -> sys_req=0, READY=1 and cpu_din=FF with no clock edge.
- Abort: a second ALE fall during REQ -> bus_error pulses, the new address is latched, and the state is ARMED. A sys_ack arriving 1 cycle later is ignored and cpu_din is unchanged.
